// File: rtl/avg_sched_pkg.sv
// Shared types and width helpers for the round-robin averaging scheduler.
package avg_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t COLLECT = 2'd1;
  localparam state_t DONE    = 2'd2;

  // A single channel still needs a one-bit index field.
  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // One extra bit so the counter can represent N itself.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/avg_scheduler_if.sv
// Sample-request and averaged-result bundle between sources, scheduler and consumers.
interface avg_scheduler_if #(
  parameter int NCH = 4,
  parameter int BW  = 4
);
  import avg_sched_pkg::*;

  localparam int CH_W = ch_width(NCH);

  logic                en;
  logic                busy;
  logic [NCH-1:0]      req_valid;
  logic [NCH*BW-1:0]   req_data;
  logic [NCH-1:0]      req_ready;
  logic                out_val;
  logic [BW-1:0]       out_avg;
  logic [CH_W-1:0]     out_ch;

  modport master (
    output en, req_valid, req_data,
    input  req_ready, out_val, out_avg, out_ch, busy
  );

  modport slave (
    input  en, req_valid, req_data,
    output req_ready, out_val, out_avg, out_ch, busy
  );

endinterface

// File: rtl/avg_scheduler_rr_arbiter.sv
// Combinational rotate-priority pick: first requester at or above ptr, wrapping upward.
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NCH]) begin
        gnt_idx = CH_W'((int'(ptr) + i) % NCH);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avg_scheduler.sv
// Time-shares one N-sample averaging datapath between NCH round-robin requesters.
module avg_scheduler
  import avg_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int N   = 4,
  parameter int BW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  avg_scheduler_if.slave  bus
);

  localparam int CH_W  = ch_width(NCH);
  localparam int CNT_W = cnt_width(N);
  localparam int LOG_N = $clog2(N);
  localparam int ACC_W = BW + LOG_N;

  state_t            state;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_any;
  logic [ACC_W-1:0]  accum;
  logic [ACC_W-1:0]  accum_nxt;
  logic [CNT_W-1:0]  count;
  logic [BW-1:0]     sample;
  logic              accept;
  logic [BW-1:0]     avg_q;
  logic [CH_W-1:0]   ch_q;

  rr_arbiter #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign sample    = bus.req_data[grant*BW +: BW];
  assign accept    = (state == COLLECT) && bus.req_valid[grant];
  assign accum_nxt = accum + ACC_W'(sample);

  // Ready comes from registers only, so sources see no path from their own valid.
  always_comb begin
    bus.req_ready = '0;
    if (state == COLLECT) bus.req_ready[grant] = 1'b1;
  end

  assign bus.busy    = (state != IDLE);
  assign bus.out_val = (state == DONE);
  assign bus.out_avg = avg_q;
  assign bus.out_ch  = ch_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      accum  <= '0;
      count  <= '0;
      avg_q  <= '0;
      ch_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en && arb_any) begin
            grant <= arb_idx;
            accum <= '0;
            count <= '0;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            accum <= accum_nxt;
            count <= count + 1'b1;
            if (count == CNT_W'(N - 1)) begin
              // Top BW bits of the full-width sum are the truncated mean.
              avg_q  <= accum_nxt[ACC_W-1 -: BW];
              ch_q   <= grant;
              rr_ptr <= (grant == CH_W'(NCH - 1)) ? '0 : grant + 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avg_scheduler.sv
// Directed bench for avg_scheduler with NCH=4, N=4, BW=4 and per-channel sample feeders.
module tb_avg_scheduler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  avg_scheduler_if #(.NCH(4), .BW(4)) bus ();

  avg_scheduler #(.NCH(4), .N(4), .BW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Per-channel sample queues; -1 means "valid low for one cycle".
  int feed [4][$];
  int res_ch [$];
  int res_avg [$];
  int gnt_q [$];
  int acc_total;
  logic [3:0] prev_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: observe at the falling edge, then drive inputs for the next rising edge.
  task automatic cyc();
    logic [3:0]  v;
    logic [15:0] d;
    int          s;
    @(negedge clk);
    chk("ready_onehot", 32'($onehot0(bus.req_ready)), 1);
    if (bus.out_val) begin
      res_ch.push_back(int'(bus.out_ch));
      res_avg.push_back(int'(bus.out_avg));
    end
    if (bus.req_ready != 4'b0 && prev_rdy == 4'b0)
      for (int c = 0; c < 4; c++) if (bus.req_ready[c]) gnt_q.push_back(c);
    prev_rdy = bus.req_ready;
    v = '0;
    d = '0;
    for (int c = 0; c < 4; c++) begin
      if (feed[c].size() != 0) begin
        s = feed[c][0];
        if (s < 0) begin
          void'(feed[c].pop_front());
        end else begin
          v[c]         = 1'b1;
          d[c*4 +: 4]  = s[3:0];
          if (bus.req_ready[c]) begin
            void'(feed[c].pop_front());
            acc_total++;
          end
        end
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
  endtask

  task automatic clear();
    for (int c = 0; c < 4; c++) feed[c].delete();
    res_ch.delete();
    res_avg.delete();
    gnt_q.delete();
    bus.req_valid = '0;
    acc_total     = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    clear();
  endtask

  task automatic run_results(input int n, input int budget);
    int k = 0;
    while (res_ch.size() < n && k < budget) begin
      cyc();
      k++;
    end
    chk("result_count", res_ch.size(), n);
  endtask

  task automatic chk_res(input string tag, input int i, input int ch, input int avg);
    if (i < res_ch.size()) begin
      chk($sformatf("%s_ch%0d", tag, i), res_ch[i], ch);
      chk($sformatf("%s_avg%0d", tag, i), res_avg[i], avg);
    end
  endtask

  task automatic chk_gnt(input string tag, input int i, input int ch);
    if (i < gnt_q.size()) chk($sformatf("%s_gnt%0d", tag, i), gnt_q[i], ch);
  endtask

  task automatic wait_accepts(input int n, input int budget);
    int k = 0;
    while (acc_total < n && k < budget) begin
      cyc();
      k++;
    end
    chk("accept_count", acc_total, n);
  endtask

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    prev_rdy      = '0;
    acc_total     = 0;
    #1;
    chk("rst_out_val", bus.out_val, 0);
    chk("rst_out_avg", bus.out_avg, 0);
    chk("rst_out_ch",  bus.out_ch, 0);
    chk("rst_busy",    bus.busy, 0);
    chk("rst_ready",   bus.req_ready, 0);
    cyc();
    cyc();
    rst = 1'b0;

    // Single requester: ch2 sends 1,2,3,4, result one cycle after the 4th accept.
    clear();
    feed[2] = '{1, 2, 3, 4};
    wait_accepts(4, 40);
    chk("t1_ready", bus.req_ready, 4'b0100);
    cyc();
    chk("t1_val",  bus.out_val, 1);
    chk("t1_avg",  bus.out_avg, 2);
    chk("t1_ch",   bus.out_ch, 2);
    cyc();
    chk("t1_val_low", bus.out_val, 0);
    chk("t1_avg_hold", bus.out_avg, 2);
    chk("t1_busy", bus.busy, 0);

    // Pointer now at 3: ch3 wins over ch0, then ch0 after the wrap.
    clear();
    feed[3] = '{0, 1, 2, 3};
    feed[0] = '{5, 6, 7, 8};
    run_results(2, 60);
    chk_res("t6", 0, 3, 1);
    chk_res("t6", 1, 0, 6);
    chk_gnt("t6", 0, 3);
    chk_gnt("t6", 1, 0);

    // All channels requesting from a fresh pointer.
    do_reset();
    feed[0] = '{1, 2, 3, 4, 9, 9, 9, 9};
    feed[1] = '{0, 1, 2, 3};
    feed[2] = '{15, 14, 13, 12};
    feed[3] = '{7, 8, 9, 10};
    run_results(5, 100);
    chk_res("t2", 0, 0, 2);
    chk_res("t2", 1, 1, 1);
    chk_res("t2", 2, 2, 13);
    chk_res("t2", 3, 3, 8);
    chk_res("t2", 4, 0, 9);
    chk("t2_gnt_count", gnt_q.size(), 5);
    for (int i = 0; i < 5; i++) chk_gnt("t2", i, i % 4);

    // ch1 stalls mid-window; ch3 must wait for it.
    do_reset();
    feed[1] = '{15, 15, -1, -1, -1, 15, 15};
    feed[3] = '{4, 4, 4, 4};
    run_results(2, 80);
    chk_res("t3", 0, 1, 15);
    chk_res("t3", 1, 3, 4);
    chk("t3_gnt_count", gnt_q.size(), 2);
    chk_gnt("t3", 0, 1);
    chk_gnt("t3", 1, 3);

    // en low blocks new grants; a started window still completes.
    do_reset();
    bus.en = 1'b0;
    for (int c = 0; c < 4; c++) feed[c] = '{3, 3, 3, 3};
    repeat (10) begin
      cyc();
      chk("t4_idle_busy", bus.busy, 0);
      chk("t4_idle_ready", bus.req_ready, 0);
    end
    clear();
    bus.en = 1'b1;
    feed[2] = '{5, 5, 5, 5};
    wait_accepts(1, 20);
    bus.en = 1'b0;
    run_results(1, 40);
    chk_res("t4", 0, 2, 5);
    feed[0] = '{1, 1, 1, 1};
    repeat (8) begin
      cyc();
      chk("t4_after_busy", bus.busy, 0);
    end
    clear();
    bus.en = 1'b1;

    // Asynchronous reset after two accepted samples discards the partial sum.
    feed[0] = '{9, 9, 9, 9};
    wait_accepts(2, 20);
    cyc();
    chk("t5_busy_pre", bus.busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_out_val", bus.out_val, 0);
    chk("t5_out_avg", bus.out_avg, 0);
    chk("t5_out_ch",  bus.out_ch, 0);
    chk("t5_busy",    bus.busy, 0);
    chk("t5_ready",   bus.req_ready, 0);
    cyc();
    rst = 1'b0;
    clear();
    feed[0] = '{4, 4, 4, 4};
    run_results(1, 40);
    chk_res("t5", 0, 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
